// File: rtl/ysyx_24100006_ifu_ctrl.sv
// Instruction fetch controller: one AXI-lite style read per instruction, handed to decode,
// then parked until write-back supplies the next PC.
module ysyx_24100006_ifu_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_arvalid,
    input  logic        im_arready,
    output logic [31:0] im_araddr,
    input  logic        im_rvalid,
    output logic        im_rready,
    input  logic [31:0] im_rdata,
    input  logic [1:0]  im_rresp,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_fault,
    input  logic        wb_valid,
    input  logic [31:0] wb_dnpc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {StAr, StR, StOut, StWait} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic [31:0] cnt;
    logic        arvalid;
    logic        rready;
    logic        ifvalid;

    // Handshake outputs are registered so they are all low while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StAr;
            pc      <= RESET_PC;
            inst    <= 32'h0;
            fault   <= 1'b0;
            cnt     <= 32'h0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            ifvalid <= 1'b0;
        end else begin
            case (state)
                StAr: begin
                    if (arvalid && im_arready) begin
                        state   <= StR;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end else begin
                        arvalid <= 1'b1;
                    end
                end
                StR: begin
                    if (im_rvalid) begin
                        state   <= StOut;
                        inst    <= im_rdata;
                        fault   <= (im_rresp != 2'b00);
                        rready  <= 1'b0;
                        ifvalid <= 1'b1;
                    end
                end
                StOut: begin
                    if (id_ready) begin
                        state   <= StWait;
                        ifvalid <= 1'b0;
                        cnt     <= cnt + 32'd1;
                    end
                end
                StWait: begin
                    if (wb_valid) begin
                        pc <= wb_dnpc;
                        if (wb_dnpc[1:0] == 2'b00) begin
                            state   <= StAr;
                            arvalid <= 1'b1;
                        end else begin
                            // Misaligned target: report a fault without touching memory.
                            state   <= StOut;
                            inst    <= 32'h0;
                            fault   <= 1'b1;
                            ifvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StAr;
                end
            endcase
        end
    end

    assign im_arvalid = arvalid;
    assign im_araddr  = pc;
    assign im_rready  = rready;
    assign if_valid   = ifvalid;
    assign if_inst    = inst;
    assign if_pc      = pc;
    assign if_fault   = fault;
    assign fetch_cnt  = cnt;

endmodule
